// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C frame slave: receiver states and default bus/frame parameters.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    DATA_ACK,
    IGNORE
  } state_e;

  localparam logic [6:0] DEF_ADDRESS     = 7'b0001101;
  localparam int         DEF_FRAME_BYTES = 13;

endpackage

// File: rtl/i2c_frame_slave_if.sv
// Frame delivery bundle between the I2C frame slave (producer) and downstream logic (consumer).
interface i2c_frame_slave_if
  import i2c_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES
);

  logic [8*FRAME_BYTES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_error;
  logic                     busy;

  modport slave  (output frame_data, frame_valid, frame_error, busy);
  modport master (input  frame_data, frame_valid, frame_error, busy);

endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and reports registered SCL edges, START and STOP conditions.
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchroniser, [2] is the previous synchronised value
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic       scl_rise_q, scl_rise_d;
  logic       scl_fall_q, scl_fall_d;
  logic       sda_s_q,    sda_s_d;
  logic       start_q,    start_d;
  logic       stop_q,     stop_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
    scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
    scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
    sda_s_d    = sda_sync_q[1];
    start_d    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
    stop_d     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
  end

  // Reset to the idle-bus level so releasing reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      sda_s_q    <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      sda_s_q    <= sda_s_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign sda_s     = sda_s_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_frame_slave.sv
// I2C write-only slave that accumulates data bytes across transactions into a fixed-size frame.
module i2c_frame_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS        = DEF_ADDRESS,
  parameter int         FRAME_BYTES    = DEF_FRAME_BYTES,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               i2c_scl,
  inout  wire               i2c_sda,
  i2c_frame_slave_if.slave  frm
);

  localparam int FW  = 8 * FRAME_BYTES;
  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst_n     (rst),
    .scl_i     (i2c_scl),
    .sda_i     (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             ack_ph_q, ack_ph_d;
  logic             sda_oe_q, sda_oe_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic [FW-1:0]    frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             busy_q, busy_d;
  logic [7:0]       shift_q, shift_d;
  logic [FW-1:0]    buf_q, buf_d;
  logic [7:0]       byte_in;

  assign byte_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    ack_ph_d      = ack_ph_q;
    sda_oe_d      = sda_oe_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = to_cnt_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    shift_d       = shift_q;
    buf_d         = buf_q;

    unique case (state_q)
      ADDR: if (scl_rise) begin
        shift_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
        ack_ph_d  = 1'b0;
        if (bit_cnt_q == 3'd7)
          state_d = (byte_in == {ADDRESS, 1'b0}) ? ADDR_ACK : IGNORE;
      end
      ADDR_ACK: if (scl_fall) begin
        // First fall starts the ACK bit, second fall ends it
        if (!ack_ph_q) begin
          ack_ph_d = 1'b1;
          sda_oe_d = 1'b1;
        end else begin
          ack_ph_d  = 1'b0;
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = RX_BYTE;
        end
      end
      RX_BYTE: if (scl_rise) begin
        shift_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
        ack_ph_d  = 1'b0;
        if (bit_cnt_q == 3'd7) state_d = DATA_ACK;
      end
      DATA_ACK: if (scl_fall) begin
        if (!ack_ph_q) begin
          ack_ph_d = 1'b1;
          // A full buffer NACKs further bytes instead of wrapping
          if (byte_cnt_q < BCW'(FRAME_BYTES)) begin
            buf_d      = {buf_q[FW-9:0], shift_q};
            byte_cnt_d = byte_cnt_q + BCW'(1);
            sda_oe_d   = 1'b1;
          end
        end else begin
          ack_ph_d  = 1'b0;
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = RX_BYTE;
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      ack_ph_d = 1'b0;
      sda_oe_d = 1'b0;
      if (byte_cnt_q == BCW'(FRAME_BYTES)) begin
        frame_data_d  = buf_q;
        frame_valid_d = 1'b1;
        byte_cnt_d    = '0;
      end
    end

    // Partial frames only age while the bus is idle between transactions
    if (state_q == IDLE && !start_det && byte_cnt_q != '0 &&
        byte_cnt_q < BCW'(FRAME_BYTES)) begin
      if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
        frame_error_d = 1'b1;
        byte_cnt_d    = '0;
        buf_d         = '0;
        to_cnt_d      = '0;
      end else begin
        to_cnt_d = to_cnt_q + TOW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    busy_d = (byte_cnt_d != '0) || (state_d inside {ADDR_ACK, RX_BYTE, DATA_ACK});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      ack_ph_q      <= 1'b0;
      sda_oe_q      <= 1'b0;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ack_ph_q      <= ack_ph_d;
      sda_oe_q      <= sda_oe_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  // Byte shifter and frame buffer are qualified by byte_count, so they need no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    buf_q   <= buf_d;
  end

  assign i2c_sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign frm.frame_data  = frame_data_q;
  assign frm.frame_valid = frame_valid_q;
  assign frm.frame_error = frame_error_q;
  assign frm.busy        = busy_q;

endmodule
